// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package ex_muldiv_pkg;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } md_state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// rtl/ex_muldiv_div.sv - iterative unsigned restoring divider, one quotient bit per cycle
module ex_muldiv_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        active_q;
  logic [32:0] partial;
  logic [32:0] diff;

  // Partial remainder shifted left by one with the next dividend bit;
  // a borrow out of bit 32 means the divisor did not fit.
  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (abort) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      quo_q    <= dividend;
      rem_q    <= '0;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (diff[32]) begin
        rem_q <= partial[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end else begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) active_q <= 1'b0;
    end
  end

  // High during the final step, so the caller can enter DONE on the same edge.
  assign ready     = active_q & (cnt_q == 5'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage RV32M multiply/divide unit with stall request
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e   state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, res_q;
  logic        special_q, neg_quo_q, neg_rem_q;

  logic        accept, signed_div, div_zero, div_ovf, special_in, div_load;
  logic [31:0] special_res, abs_a, abs_b;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix, mul_res;
  logic        div_ready;
  logic [32:0] a_ext, b_ext;
  logic signed [65:0] product;

  assign accept      = (state_q == IDLE) & start & ~flush;
  assign signed_div  = ~funct3[0];
  assign div_zero    = (src_b == '0);
  assign div_ovf     = signed_div & (src_a == INT_MIN) & (src_b == 32'hFFFF_FFFF);
  assign special_in  = div_zero | div_ovf;
  assign special_res = funct3[1] ? (div_zero ? src_a : 32'd0)
                                 : (div_zero ? DIV_ZERO_Q : INT_MIN);
  assign abs_a       = neg_if(signed_div & src_a[31], src_a);
  assign abs_b       = neg_if(signed_div & src_b[31], src_b);
  assign div_load    = accept & funct3[2] & ~special_in;

  ex_muldiv_div u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (flush),
    .load      (div_load),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .ready     (div_ready)
  );

  // 33-bit extension lets one signed multiplier cover all four MUL variants.
  assign a_ext   = {((op_q == OP_MULH) | (op_q == OP_MULHSU)) & a_q[31], a_q};
  assign b_ext   = {(op_q == OP_MULH) & b_q[31], b_q};
  assign product = $signed(a_ext) * $signed(b_ext);
  assign mul_res = (op_q == OP_MUL) ? product[31:0] : product[63:32];

  assign quo_fix = neg_if(neg_quo_q, div_quo);
  assign rem_fix = neg_if(neg_rem_q, div_rem);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!funct3[2])     state_d = MUL;
          else if (special_in) state_d = DONE;
          else                 state_d = DIV;
        end
      end
      MUL:  state_d = DONE;
      DIV:  if (div_ready) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        done    = rst_n;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      special_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= funct3;
        a_q       <= src_a;
        b_q       <= src_b;
        res_q     <= special_res;
        special_q <= funct3[2] & special_in;
        neg_quo_q <= signed_div & (src_a[31] ^ src_b[31]);
        neg_rem_q <= signed_div & src_a[31];
      end
      if (state_q == MUL) res_q <= mul_res;
    end
  end

  assign result = (op_q[2] & ~special_q) ? (op_q[1] ? rem_fix : quo_fix) : res_q;
  assign busy   = rst_n & start & ~done & ~flush;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b, result;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pu;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = 64'(a) * 64'(b); return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drives an op in the current (IDLE) cycle and waits for done. Returns at a negedge
  // in an IDLE cycle unless keep is set, in which case it returns in the DONE cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit keep, output logic [31:0] res, output int lat, output int bcnt);
    funct3 = f;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    lat    = -1;
    bcnt   = 0;
    res    = 'x;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      else #1;
      if (c == 1) begin
        src_a = $urandom;
        src_b = $urandom;
      end
      if (busy) bcnt++;
      if (done) begin
        res = result;
        lat = c;
        break;
      end
    end
    if (!keep) begin
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, ra, rb;
    logic [2:0]  rf;
    int          lat, bcnt;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[2]  = '{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    vecs[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    vecs[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
    vecs[13] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};

    rst_n  = 1'b0;
    start  = 1'b1;
    flush  = 1'b0;
    funct3 = 3'd4;
    src_a  = 32'd9;
    src_b  = 32'd3;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    chk("reset_done2", {31'b0, done}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, res, lat, bcnt);
      chk($sformatf("vec%0d_res", i), res, vecs[i].res);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].lat));
    end

    for (int n = 0; n < 40; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf, ra, rb, 1'b0, res, lat, bcnt);
      chk($sformatf("rnd%0d_f%0d_res", n, rf), res, model(rf, ra, rb));
      chk($sformatf("rnd%0d_f%0d_lat", n, rf), 32'(lat), 32'(model_lat(rf, ra, rb)));
    end

    // Flush in cycle t+10 of a divide, then a multiply started at t+11.
    funct3 = 3'd4;
    src_a  = 32'd1000;
    src_b  = 32'd3;
    start  = 1'b1;
    #1;
    chk("flush_t0_busy", {31'b0, busy}, 32'd1);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("flush_t%0d_busy_done", c), {30'b0, busy, done}, 32'b10);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_t10_busy_done", {30'b0, busy, done}, 32'b00);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("flush_t11_done", {31'b0, done}, 32'd0);
    run_op(3'd0, 32'h0001_2345, 32'h0000_0100, 1'b0, res, lat, bcnt);
    chk("flush_mul_res", res, 32'h0123_4500);
    chk("flush_mul_lat", 32'(lat), 32'd2);

    // Reset pulse in the middle of a divide.
    funct3 = 3'd5;
    src_a  = 32'd12345;
    src_b  = 32'd7;
    start  = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {30'b0, busy, done}, 32'b00);
    @(negedge clk);
    chk("midrst_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    run_op(3'd5, 32'd12345, 32'd7, 1'b0, res, lat, bcnt);
    chk("midrst_divu_res", res, 32'd1763);
    chk("midrst_divu_lat", 32'(lat), 32'd33);

    // Back-to-back: DIV then MUL with no idle cycle between.
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 1'b1, res, lat, bcnt);
    chk("b2b_div_res", res, 32'hFFFF_FFF2);
    chk("b2b_div_lat", 32'(lat), 32'd33);
    funct3 = 3'd0;
    src_a  = 32'd9;
    src_b  = 32'd11;
    @(negedge clk);
    run_op(3'd0, 32'd9, 32'd11, 1'b0, res, lat, bcnt);
    chk("b2b_mul_res", res, 32'd99);
    chk("b2b_mul_lat", 32'(lat), 32'd2);
    chk("b2b_mul_busy", 32'(bcnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
